// File: rtl/br_pred_track.sv
`default_nettype none
// ============================================================================
//  Module   : br_pred_track
//  Purpose  : In-order tracker for in-flight conditional branches between
//             fetch and commit. Records each fetch-time prediction, accepts
//             out-of-order resolutions from execute by tag, and on an
//             in-order commit drives the predictor's training (update) port.
//
//  Ports    : clk, reset        - clock, synchronous active-high reset
//             flush_            - active-low squash of all tracked branches
//             pred_valid_/pc/taken, pred_tag, full, empty
//                               - fetch-side allocation interface
//             res_valid_/tag/taken
//                               - execute-side resolution interface
//             commit_           - active-low retire request for the oldest
//             commit_pc, br_commit_, br_result, br_pred_miss_
//                               - registered predictor update outputs
//
//  Revision : 1.0 - initial release
// ============================================================================
module br_pred_track #(
    parameter int ADDR  = 32,
    parameter int DEPTH = 8,
    parameter int TAGW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_,
    input  logic            pred_valid_,
    input  logic [ADDR-1:0] pred_pc,
    input  logic            pred_taken,
    output logic [TAGW-1:0] pred_tag,
    output logic            full,
    output logic            empty,
    input  logic            res_valid_,
    input  logic [TAGW-1:0] res_tag,
    input  logic            res_taken,
    input  logic            commit_,
    output logic [ADDR-1:0] commit_pc,
    output logic            br_commit_,
    output logic            br_result,
    output logic            br_pred_miss_
);

    localparam logic [TAGW:0] c_PTR_ONE = {{TAGW{1'b0}}, 1'b1};

    // Entry storage: one bit per entry for the flags, PC array alongside.
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_resolved;
    logic [DEPTH-1:0] r_pred;
    logic [DEPTH-1:0] r_result;
    logic [ADDR-1:0]  r_pc [DEPTH];

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [TAGW:0]    r_head;
    logic [TAGW:0]    r_tail;

    // Registered update-port outputs.
    logic             r_br_commit_n;
    logic [ADDR-1:0]  r_commit_pc;
    logic             r_br_result;
    logic             r_br_pred_miss_n;

    logic [TAGW-1:0]  w_head_idx;
    logic [TAGW-1:0]  w_tail_idx;
    logic             w_full;
    logic             w_empty;
    logic             w_alloc;
    logic             w_resolve;
    logic             w_commit;

    assign w_head_idx = r_head[TAGW-1:0];
    assign w_tail_idx = r_tail[TAGW-1:0];

    assign w_full  = (r_head[TAGW] != r_tail[TAGW]) && (w_head_idx == w_tail_idx);
    assign w_empty = (r_head == r_tail);

    // Allocation looks only at the registered full flag, so a commit freeing
    // a slot in the same cycle does not let a request in.
    assign w_alloc   = !pred_valid_ && !w_full;
    assign w_resolve = !res_valid_ && r_valid[res_tag];
    // Resolved bit is sampled before this cycle's resolve lands, so a head
    // resolved in the same cycle does not commit yet.
    assign w_commit  = !commit_ && !w_empty && r_resolved[w_head_idx];

    // Entry and pointer state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= '0;
            r_resolved <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else if (!flush_) begin
            // Squash dominates allocate and resolve in the same cycle.
            r_valid    <= '0;
            r_resolved <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            // Allocate and commit never target the same slot: allocate needs
            // not-full and commit needs not-empty, which forces head != tail
            // in index whenever both fire.
            if (w_alloc) begin
                r_valid[w_tail_idx]    <= 1'b1;
                r_resolved[w_tail_idx] <= 1'b0;
                r_pc[w_tail_idx]       <= pred_pc;
                r_pred[w_tail_idx]     <= pred_taken;
                r_result[w_tail_idx]   <= 1'b0;
                r_tail                 <= r_tail + c_PTR_ONE;
            end
            if (w_resolve) begin
                r_resolved[res_tag] <= 1'b1;
                r_result[res_tag]   <= res_taken;
            end
            // Placed last so retiring the head wins over a late resolve to it.
            if (w_commit) begin
                r_valid[w_head_idx]    <= 1'b0;
                r_resolved[w_head_idx] <= 1'b0;
                r_head                 <= r_head + c_PTR_ONE;
            end
        end
    end

    // Update-port outputs. A commit coinciding with a flush is still emitted:
    // it is the oldest branch and retires ahead of the squash.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_br_commit_n    <= 1'b1;
            r_commit_pc      <= '0;
            r_br_result      <= 1'b0;
            r_br_pred_miss_n <= 1'b1;
        end else begin
            r_br_commit_n <= !w_commit;
            if (w_commit) begin
                r_commit_pc      <= r_pc[w_head_idx];
                r_br_result      <= r_result[w_head_idx];
                r_br_pred_miss_n <= !(r_pred[w_head_idx] ^ r_result[w_head_idx]);
            end
        end
    end

    assign pred_tag      = w_tail_idx;
    assign full          = w_full;
    assign empty         = w_empty;
    assign commit_pc     = r_commit_pc;
    assign br_commit_    = r_br_commit_n;
    assign br_result     = r_br_result;
    assign br_pred_miss_ = r_br_pred_miss_n;

endmodule
`default_nettype wire

// File: doc/br_pred_track.md
Name: br_pred_track

Overview:
- In-order tracker for in-flight conditional branches between fetch and commit.
- Records each fetch-time prediction (PC, predicted direction) and accepts out-of-order resolutions from execute by tag.
- On an in-order commit request, drives the predictor's training interface: commit_pc, br_commit_, br_result and br_pred_miss_.
- It is the producer end of the gshare predictor's update port.

Parameters:
- ADDR, 32, PC width.
- DEPTH, 8, maximum in-flight branches; power of two, at least 2.
- TAGW, $clog2(DEPTH), entry tag width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush_  in  1  active-low; squash all tracked branches
- pred_valid_  in  1  active-low; fetch allocates an entry
- pred_pc  in  ADDR  PC of the predicted branch
- pred_taken  in  1  predicted direction, 1 = taken
- pred_tag  out  TAGW  tag of the next entry to allocate (the tail index)
- full  out  1  no free entry
- empty  out  1  no tracked entry
- res_valid_  in  1  active-low; execute resolves a branch
- res_tag  in  TAGW  tag being resolved
- res_taken  in  1  actual direction
- commit_  in  1  active-low; ROB retires the oldest branch
- commit_pc  out  ADDR  PC of the retired branch
- br_commit_  out  1  active-low, one-cycle update strobe
- br_result  out  1  actual direction of the retired branch
- br_pred_miss_  out  1  active-low; retired branch was mispredicted

Behaviour:
- Storage is a circular buffer of DEPTH entries. Each entry holds {valid, resolved, pc, pred, result}.
- Head and tail pointers are TAGW+1 bits; the MSB is the wrap bit.
- full = (head, tail differ only in the MSB). empty = (head == tail). Both are derived from registered state only.
- pred_tag = tail[TAGW-1:0], combinational from registered state.
- Allocate:
  - Condition: pred_valid_=0 and full=0.
  - Write entry[tail] = {1, 0, pred_pc, pred_taken, 0}, then tail+1.
  - While full=1 the request is dropped, even if a commit frees a slot in the same cycle.
- Resolve:
  - Condition: res_valid_=0 and entry[res_tag].valid=1.
  - Effect: set resolved=1 and result=res_taken.
  - A resolve to an invalid entry is ignored.
  - A repeated resolve overwrites result.
- Commit:
  - Condition: commit_=0, empty=0, and entry[head].resolved=1 at the start of the cycle.
  - Next edge: br_commit_=0, commit_pc=pc, br_result=result, br_pred_miss_ = ~(pred ^ result); clear entry valid; head+1.
  - The output is therefore registered with 1-cycle latency.
  - Commit is ignored when empty, or when the head is unresolved, including when the head is resolved in the same cycle.
- Update outputs:
  - br_commit_ returns to 1 on the following cycle unless another commit fires.
  - commit_pc, br_result and br_pred_miss_ hold their last values when br_commit_=1.
  - Back-to-back commits produce consecutive strobes.
- Flush (flush_=0):
  - All valid bits are cleared; head = tail = 0.
  - Any allocate or resolve in the same cycle is discarded.
  - A qualifying commit in the same cycle is still emitted on the outputs. It is the oldest branch and precedes the squash.
- Wrap-around: pointers increment modulo 2·DEPTH; tags reuse indices after wrap.
- Simultaneous allocate and commit when not full: both occur; the count is unchanged.
- Reset (reset=1, synchronous, dominates flush_ and all requests):
  - All entries invalid; head = tail = 0.
  - br_commit_=1, commit_pc=0, br_result=0, br_pred_miss_=1.
  - full=0, empty=1, pred_tag=0.
  - Reset asserted mid-operation discards all state on that edge.

Test Plan:
- Reset, then allocate PC 0x100 with pred_taken=1 (tag 0), resolve tag 0 with res_taken=1, then commit -> one cycle later br_commit_=0, commit_pc=0x100, br_result=1, br_pred_miss_=1; next cycle br_commit_=1.
- Allocate 0x200 (pred 0), resolve taken=1, commit -> br_pred_miss_=0, br_result=1.
- Allocate 8 entries -> full=1; a 9th allocate is dropped and pred_tag stays 0; commit 8 in order -> PCs emerge in allocation order; empty=1; the next allocate gets tag 0 (wrap).
- Allocate tags 0..2, resolve in order 2,1,0 -> commits of tags 1 and 2 issued before tag 0 resolves produce no strobe; after tag 0 resolves, three commits emit the PCs for tags 0,1,2 in order.
- Flush asserted in the same cycle as an allocate and a valid head commit -> the commit strobe appears; next cycle empty=1 and pred_tag=0; a later resolve of the old tag is ignored.
- Reset asserted while 4 entries are valid and a commit is pending -> next cycle br_commit_=1, empty=1, full=0, commit_pc=0.
